icache_fetch_unit: RTL and testbench

Direct-mapped instruction cache between the datapath fetch stage and the memory controller's instruction port (iREN/iaddr/iwait/iload).
- Hit: returns the instruction word in the same cycle.
- Miss: issues one word read to the memory controller, fills the frame, then hits on the following cycle.
- Supports full invalidation, used on halt and self-modifying-code flushes.

---
 rtl/icache_fetch_unit_pkg.sv | 25 ++
 rtl/icache_fetch_unit_if.sv | 18 +
 rtl/icache_fetch_unit_frame_array.sv | 46 ++++
 rtl/icache_fetch_unit.sv | 111 +++++++++++
 tb/tb_icache_fetch_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/icache_fetch_unit_pkg.sv
// Shared CPU types for the instruction cache fetch path (package cpu_types_pkg).
// Optional build macro used by the cache: ICACHE_STATS_EN.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave: the cache's view; master: the datapath/memory controller view.
interface icache_fetch_unit_if;
  logic                 imemREN;
  cpu_types_pkg::word_t imemaddr;
  logic                 ihit;
  cpu_types_pkg::word_t imemload;
  logic                 inval;
  logic                 iREN;
  cpu_types_pkg::word_t iaddr;
  logic                 iwait;
  cpu_types_pkg::word_t iload;

  modport slave  (input  imemREN, imemaddr, inval, iwait, iload,
                  output ihit, imemload, iREN, iaddr);
  modport master (output imemREN, imemaddr, inval, iwait, iload,
                  input  ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_fetch_unit_frame_array.sv
// Frame storage for the direct-mapped instruction cache: one write port,
// a bulk valid clear, and a combinational read by index.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             clear_all,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output word_t            rdata
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  word_t            datas [SETS];

  // Valid bits: bulk clear wins over a fill landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (clear_all)
      valid <= '0;
    else if (we)
      valid[widx] <= 1'b1;
  end

  // Tag/data payload; only meaningful once the valid bit is set.
  always_ff @(posedge CLK) begin
    if (we) begin
      tags[widx]  <= wtag;
      datas[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = datas[ridx];

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache between fetch stage and memory controller.
// Optional macro ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                CLK,
  input  logic                RST,
  icache_fetch_unit_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output word_t               hit_count,
  output word_t               miss_count
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  icache_state_t    state, state_next;
  word_t            miss_addr, miss_addr_next;
  logic             rvalid;
  logic [TAG_W-1:0] rtag;
  word_t            rdata;
  logic             fill_we;
  logic             clear_all;

  // RST and inval share the bulk clear; a fill is never written alongside it.
  assign clear_all = RST | bus.inval;

  icache_frame_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK       (CLK),
    .clear_all (clear_all),
    .we        (fill_we & ~clear_all),
    .widx      (miss_addr[IDX_W+1:2]),
    .wtag      (miss_addr[31:IDX_W+2]),
    .wdata     (bus.iload),
    .ridx      (bus.imemaddr[IDX_W+1:2]),
    .rvalid    (rvalid),
    .rtag      (rtag),
    .rdata     (rdata)
  );

  // State and latched miss address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state     <= state_next;
      miss_addr <= miss_addr_next;
    end
  end

  // Next state, hit detection and memory request; all outputs held low in reset.
  always_comb begin
    state_next     = state;
    miss_addr_next = miss_addr;
    fill_we        = 1'b0;
    bus.ihit       = 1'b0;
    bus.imemload   = '0;
    bus.iREN       = 1'b0;
    bus.iaddr      = '0;
    unique case (state)
      IDLE: begin
        if (bus.imemREN && rvalid && (rtag == bus.imemaddr[31:IDX_W+2])) begin
          bus.ihit     = 1'b1;
          bus.imemload = rdata;
        end else if (bus.imemREN) begin
          miss_addr_next = {bus.imemaddr[31:2], 2'b00};
          state_next     = FETCH;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
        if (!bus.iwait) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
        if (bus.inval)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (RST) begin
      bus.ihit     = 1'b0;
      bus.imemload = '0;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      fill_we      = 1'b0;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters; cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_next == FETCH && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench for icache_fetch_unit: reference cache model plus
// a scoreboard queue of expected instruction words.
module tb_icache_fetch_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  word_t sb_q[$];

  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  word_t       m_data  [16];

  icache_fetch_unit_if bus ();

`ifdef ICACHE_STATS_EN
  word_t hit_count, miss_count;
  icache_fetch_unit dut (.CLK(CLK), .RST(RST), .bus(bus.slave),
                         .hit_count(hit_count), .miss_count(miss_count));
`else
  icache_fetch_unit dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
`endif

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch of address a; a miss is serviced with `waits` busy cycles and data d.
  task automatic access(input word_t a, input int waits, input word_t d);
    word_t w;
    logic  hit;
    hit = m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b1;
    if (hit) begin
      sb_q.push_back(m_data[a[5:2]]);
      #4;
      check_val("hit_ihit", {31'd0, bus.ihit}, 32'd1);
      check_val("hit_iren", {31'd0, bus.iREN}, 32'd0);
      w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      check_val("hit_data", bus.imemload, w);
      exp_hits++;
      step();
    end else begin
      #4;
      check_val("miss_ihit", {31'd0, bus.ihit}, 32'd0);
      exp_miss++;
      step();
      for (int k = 0; k <= waits; k++) begin
        bus.iwait = (k < waits);
        bus.iload = (k < waits) ? 32'hBAD0_0000 : d;
        if (k == waits) sb_q.push_back(d);
        #4;
        check_val("fetch_iren", {31'd0, bus.iREN}, 32'd1);
        check_val("fetch_iaddr", bus.iaddr, {a[31:2], 2'b00});
        step();
      end
      bus.iwait = 1'b1;
      m_valid[a[5:2]] = 1'b1;
      m_tag[a[5:2]]   = a[31:6];
      m_data[a[5:2]]  = d;
      #4;
      check_val("fill_ihit", {31'd0, bus.ihit}, 32'd1);
      check_val("fill_iren", {31'd0, bus.iREN}, 32'd0);
      w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      check_val("fill_data", bus.imemload, w);
      exp_hits++;
      step();
    end
  endtask

  initial begin
    model_clear();
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.inval = 1'b0;
    bus.iwait = 1'b1; bus.iload = '0;
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    #4;
    check_val("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    check_val("rst_iren", {31'd0, bus.iREN}, 32'd0);
    check_val("rst_iaddr", bus.iaddr, 32'd0);
    check_val("rst_load", bus.imemload, 32'd0);
    step();

    // Cold miss, repeat hit, conflict eviction.
    access(32'h40, 3, 32'h2001_0005);
    access(32'h40, 0, 32'h0);
    access(32'h80, 1, 32'hAAAA_AAAA);
    access(32'h40, 0, 32'h2001_0005);
`ifdef ICACHE_STATS_EN
    #4;
    check_val("stat_miss", miss_count, exp_miss);
    check_val("stat_hit", hit_count, exp_hits);
    step();
`endif

    // Address/request changes during FETCH do not disturb the fill.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h10; bus.iwait = 1'b1;
    #4; check_val("mid_miss", {31'd0, bus.ihit}, 32'd0); step();
    bus.imemaddr = 32'h20;
    #4; check_val("mid_iaddr0", bus.iaddr, 32'h10); step();
    bus.imemREN = 1'b0;
    #4; check_val("mid_iaddr1", bus.iaddr, 32'h10); step();
    bus.imemREN = 1'b1; bus.iwait = 1'b0; bus.iload = 32'h1111_0010;
    #4; check_val("mid_iaddr2", bus.iaddr, 32'h10); step();
    m_valid[4] = 1'b1; m_tag[4] = 26'd0; m_data[4] = 32'h1111_0010;
    access(32'h10, 0, 32'h0);
    access(32'h20, 2, 32'h2222_0020);

    // inval on the completing cycle of a fill.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h30; bus.iwait = 1'b1;
    #4; step();
    bus.iwait = 1'b0; bus.iload = 32'h3333_0030; bus.inval = 1'b1;
    #4; check_val("inv_iren", {31'd0, bus.iREN}, 32'd1); step();
    bus.inval = 1'b0; bus.iwait = 1'b1;
    model_clear();
    access(32'h30, 1, 32'h3333_0030);
    access(32'h10, 0, 32'h1111_0010);
    access(32'h40, 0, 32'h2001_0005);

    // inval in IDLE: same-cycle hit, then miss.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.inval = 1'b1;
    #4;
    check_val("invidle_ihit", {31'd0, bus.ihit}, 32'd1);
    check_val("invidle_data", bus.imemload, 32'h2001_0005);
    step();
    bus.inval = 1'b0;
    model_clear();
    access(32'h40, 2, 32'h4444_0040);

    // No request in IDLE.
    bus.imemREN = 1'b0; bus.imemaddr = 32'h40;
    #4;
    check_val("noreq_ihit", {31'd0, bus.ihit}, 32'd0);
    check_val("noreq_iren", {31'd0, bus.iREN}, 32'd0);
    step();
    access(32'h40, 0, 32'h0);

    // Reset mid-FETCH (with inval also asserted).
    bus.imemREN = 1'b1; bus.imemaddr = 32'h50; bus.iwait = 1'b1;
    #4; step();
    #4; check_val("rstf_iren_pre", {31'd0, bus.iREN}, 32'd1);
    RST = 1'b1; bus.inval = 1'b1; bus.iload = 32'h5555_0050;
    #1;
    check_val("rstf_iren_dur", {31'd0, bus.iREN}, 32'd0);
    check_val("rstf_iaddr_dur", bus.iaddr, 32'd0);
    step();
    RST = 1'b0; bus.inval = 1'b0; bus.imemREN = 1'b0;
    #4;
    check_val("rstf_iren", {31'd0, bus.iREN}, 32'd0);
    check_val("rstf_iaddr", bus.iaddr, 32'd0);
    step();
    model_clear();
    access(32'h40, 0, 32'h4444_0040);
    access(32'h50, 1, 32'h5555_0050);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
